// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit and the E-stage controller
// that drives its START/OP inputs.
package mult_div_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;
  localparam int MD_CNT_W       = 8;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Operations that occupy the unit for a multi-cycle latency.
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO and raises BUSY for the hazard
// unit while a fixed-latency MULT/DIV is in flight.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [2:0]  OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        BUSY,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   count_q, count_d;
  logic [63:0]           res_q, res_d;
  logic                  div_zero_q, div_zero_d;
  logic [31:0]           hi_q, hi_d, lo_q, lo_d;

  logic [63:0] prod_s, prod_u, result;
  logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, q_res, r_res;
  logic        signed_div, neg_q, neg_r, start_arith;

  // Divide works on magnitudes and restores signs afterwards, so the
  // 0x80000000 / -1 case falls out naturally as 0x80000000 rem 0.
  always_comb begin
    prod_s     = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u     = {32'b0, A} * {32'b0, B};
    signed_div = (OP == MD_DIV);
    a_mag      = (signed_div && A[31]) ? -A : A;
    b_mag      = (signed_div && B[31]) ? -B : B;
    divisor    = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag      = a_mag / divisor;
    r_mag      = a_mag % divisor;
    neg_q      = signed_div & (A[31] ^ B[31]);
    neg_r      = signed_div & A[31];
    q_res      = neg_q ? -q_mag : q_mag;
    r_res      = neg_r ? -r_mag : r_mag;
    case (OP)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      default:  result = {r_res, q_res};
    endcase
  end

  assign start_arith = START & md_is_arith(OP);
  assign BUSY        = (state_q == MD_RUN) | start_arith;
  assign HI          = hi_q;
  assign LO          = lo_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    res_d      = res_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (start_arith) begin
          res_d      = result;
          div_zero_d = (OP == MD_DIV || OP == MD_DIVU) && (B == 32'd0);
          count_d    = (OP == MD_MULT || OP == MD_MULTU) ?
                       MD_CNT_W'(MULT_CYCLES) : MD_CNT_W'(DIV_CYCLES);
          state_d    = MD_RUN;
        end else if (START && OP == MD_MTHI) begin
          hi_d = A;
        end else if (START && OP == MD_MTLO) begin
          lo_d = A;
        end
      end
      MD_RUN: begin
        count_d = count_q - MD_CNT_W'(1);
        // Last busy cycle: commit unless the divisor was zero.
        if (count_q == MD_CNT_W'(1)) begin
          state_d = MD_IDLE;
          if (!div_zero_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= MD_IDLE;
      count_q    <= '0;
      res_q      <= '0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      res_q      <= res_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random traffic
// against a cycle-timeline reference model of HI/LO and BUSY.
module tb_mult_div_unit;

  logic        CLK = 1'b0;
  logic        RESET, START;
  logic [2:0]  OP;
  logic [31:0] A, B;
  logic        BUSY;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  // Model: the cycle index at which a pending result becomes visible.
  int          cyc = 0;
  int          doneAt = 0;
  bit          pend = 0;
  bit          pendDz = 0;
  logic [31:0] pendHi, pendLo;
  logic [31:0] mHi = '0, mLo = '0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP),
    .A(A), .B(B), .BUSY(BUSY), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Returns {divide_by_zero, hi, lo} from plain arithmetic on wide integers.
  function automatic logic [64:0] refCalc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin sp = sa * sb; p = sp; return {1'b0, p}; end
      3'd1: begin p = ua * ub; return {1'b0, p}; end
      3'd2: begin
        if (b == 32'd0) return {1'b1, 64'd0};
        sq = sa / sb;
        sr = sa % sb;
        return {1'b0, sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, 64'd0};
        p = {(ua % ub), 32'b0} | (ua / ub);
        return {1'b0, p};
      end
    endcase
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge.
  task automatic applyStimulus(input bit rst, input bit st, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    logic [64:0] r;
    RESET = rst; START = st; OP = op; A = a; B = b;
    if (pend && cyc == doneAt) begin
      pend = 0;
      if (!pendDz) begin mHi = pendHi; mLo = pendLo; end
    end
    @(negedge CLK);
    checkOutput("busy", {31'b0, BUSY}, {31'b0, (cyc < doneAt) || (st && op <= 3'd3)});
    checkOutput("hi", HI, mHi);
    checkOutput("lo", LO, mLo);
    @(posedge CLK);
    if (rst) begin
      doneAt = 0; pend = 0; mHi = '0; mLo = '0;
    end else if (st && cyc >= doneAt) begin
      if (op <= 3'd3) begin
        r = refCalc(op, a, b);
        pendDz = r[64]; pendHi = r[63:32]; pendLo = r[31:0];
        pend = 1;
        doneAt = cyc + ((op <= 3'd1) ? 5 : 10) + 1;
      end else if (op == 3'd4) mHi = a;
      else if (op == 3'd5) mLo = a;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 3'd7, '0, '0);
  endtask

  initial begin
    bit          st, rst;
    logic [2:0]  op;
    logic [31:0] a, b;

    RESET = 1; START = 0; OP = '0; A = '0; B = '0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 0;
    @(negedge CLK);
    checkOutput("reset_busy", {31'b0, BUSY}, 32'd0);
    checkOutput("reset_hi", HI, 32'd0);
    checkOutput("reset_lo", LO, 32'd0);
    @(posedge CLK); #1;

    applyStimulus(0, 1, 3'd0, 32'hFFFF_FFFE, 32'd3);
    idle(6);
    checkOutput("mult_hi", HI, 32'hFFFF_FFFF);
    checkOutput("mult_lo", LO, 32'hFFFF_FFFA);

    applyStimulus(0, 1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(6);
    checkOutput("multu_hi", HI, 32'hFFFF_FFFE);
    checkOutput("multu_lo", LO, 32'h0000_0001);

    applyStimulus(0, 1, 3'd2, 32'hFFFF_FFF9, 32'd2);
    idle(11);
    checkOutput("div_hi", HI, 32'hFFFF_FFFF);
    checkOutput("div_lo", LO, 32'hFFFF_FFFD);

    applyStimulus(0, 1, 3'd4, 32'h11, '0);
    applyStimulus(0, 1, 3'd5, 32'h22, '0);
    applyStimulus(0, 1, 3'd3, 32'd7, 32'd0);
    idle(11);
    checkOutput("divz_hi", HI, 32'h11);
    checkOutput("divz_lo", LO, 32'h22);

    applyStimulus(0, 1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(2);
    applyStimulus(0, 1, 3'd0, 32'd5, 32'd5);
    idle(10);
    checkOutput("divovf_hi", HI, 32'h0);
    checkOutput("divovf_lo", LO, 32'h8000_0000);

    applyStimulus(0, 1, 3'd0, 32'd9, 32'd9);
    idle(4);
    applyStimulus(0, 1, 3'd4, 32'hDEAD_BEEF, '0);
    idle(2);
    checkOutput("edge_hi", HI, 32'h0);
    checkOutput("edge_lo", LO, 32'd81);

    applyStimulus(0, 1, 3'd0, 32'd3, 32'd4);
    idle(1);
    applyStimulus(1, 0, 3'd7, '0, '0);
    idle(1);
    checkOutput("rst_mid_hi", HI, 32'h0);
    checkOutput("rst_mid_lo", LO, 32'h0);
    applyStimulus(0, 1, 3'd0, 32'd6, 32'd7);
    idle(6);
    checkOutput("post_rst_lo", LO, 32'd42);

    for (int i = 0; i < 600; i++) begin
      st  = ($urandom_range(0, 2) == 0);
      op  = 3'($urandom_range(0, 7));
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) b = 32'hFFFF_FFFF;
      rst = ($urandom_range(0, 149) == 0);
      applyStimulus(rst, st, op, a, b);
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
